mc_router_mlane: RTL
====================

Name: mc_router_mlane

Overview:
- Multi-lane multicast router: next generation of the single-destination ID router in front of each PE.
- One bus beat (ID-tagged) is delivered to every configured lane whose latched ID matches, or to all enabled lanes on broadcast ID.
- Per-lane FIFO buffering, valid/ready backpressure to the PE and the bus, and dropped-beat accounting, none of which the old router has.
- Sits between the column bus and NUM_CH PE input ports (weight, ifmap or psum_in).

Parameters:
DATA_WIDTH, 16, bus/lane data width
ID_WIDTH, 8, tag width; all-ones value is the broadcast ID
NUM_CH, 4, number of lanes (1..16)
FIFO_DEPTH, 4, entries per lane; power of 2, >=2
CNT_WIDTH, 16, drop counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
config_state  in  1  configuration phase; bus blocked while high
ce  in  1  config latch enable (qualified by config_state)
cfg_id  in  NUM_CH*ID_WIDTH  per-lane destination ID, lane i at [i*ID_WIDTH +: ID_WIDTH]
cfg_ch_en  in  NUM_CH  per-lane enable
bus_id  in  ID_WIDTH  source tag of current beat
bus_data  in  DATA_WIDTH  beat payload
bus_valid  in  1  beat present
bus_ready  out  1  beat accepted when bus_valid&&bus_ready
pe_data  out  NUM_CH*DATA_WIDTH  per-lane FIFO head
pe_valid  out  NUM_CH  lane FIFO non-empty
pe_ready  in  NUM_CH  lane consumer ready
fifo_level  out  NUM_CH*($clog2(FIFO_DEPTH)+1)  per-lane occupancy
drop_pulse  out  1  registered 1-cycle pulse: accepted beat matched no lane
drop_cnt  out  CNT_WIDTH  saturating count of dropped beats
cfg_locked  out  1  high once configured and config_state low

Behaviour:
- Reset (rst=1 at clock edge), all outputs 0:
  - IDs 0, ch_en 0, FIFOs empty, drop_cnt 0, drop_pulse 0, cfg_locked 0.
  - bus_ready 0 while rst is high.
- Config: each cycle with config_state&&ce:
  - Latch cfg_id and cfg_ch_en into registers.
  - Flush all lane FIFOs (level to 0), clear drop_cnt.
  - Set internal cfg_seen.
- cfg_locked = cfg_seen && !config_state (registered).
- Match: match[i] = en[i] && (bus_id==id[i] || bus_id==all-ones). Uses latched registers only.
- bus_ready = !config_state && !rst && AND over i of (!match[i] || !full[i]).
  - Combinational from bus_id and registered full flags only.
  - No combinational path from pe_ready (no same-cycle pop bypass).
- Accept (bus_valid&&bus_ready):
  - Push bus_data into every matching lane simultaneously; all-or-none multicast.
  - No lane ever receives a partial multicast.
- Zero match on an accepted beat:
  - Beat consumed (bus_ready=1) and discarded.
  - drop_pulse=1 next cycle.
  - drop_cnt+1, saturating at 2^CNT_WIDTH-1.
- Latency: beat accepted at edge t is visible on pe_data/pe_valid after edge t (1 cycle). FIFO is show-ahead.
- Pop: pe_valid[i]&&pe_ready[i] removes head at the edge.
- Simultaneous push+pop on a non-empty lane: level unchanged, data order preserved.
- Empty lane: pe_ready ignored. Full lane: bus stalls only if the current beat matches that lane.
- Pointers wrap modulo FIFO_DEPTH; full = level==FIFO_DEPTH.
- bus_valid during config_state: not accepted, no drop counted.
- Config mid-operation: pending lane data is lost (flush), by design.
- pe_data of an empty lane holds its last value; consumers qualify with pe_valid.

Decomposition:
- Package oct_router_pkg:
  - BCAST_ID function (all-ones of width)
  - lvl_width(depth) = $clog2(depth)+1
  - shared lane-slicing helper
- Sub-module mc_lane_fifo (DATA_WIDTH, FIFO_DEPTH):
  - Inputs: push, pop, flush.
  - Outputs: head, empty, full, level.
  - Instantiated NUM_CH times via generate.

Test Plan:
1. Reset, then config ids {0x01,0x02,0x03,0x04}, en=4'b1111 → cfg_locked=1 two cycles after config_state falls; all pe_valid=0, fifo_level=0.
2. Beat id=0x02 data=0x1234, pe_ready=0 → lane1 pe_valid=1 next cycle, pe_data lane1=0x1234, level lane1=1, other lanes 0.
3. Broadcast id=0xFF, 4 beats 0xA0..0xA3, pe_ready=0, FIFO_DEPTH=4 → all lanes level=4; 5th beat sees bus_ready=0. Raise pe_ready[0] only → still 0 until all lanes pop; lane order A0..A3 on every lane.
4. en=4'b1011, beat id=0x03 → not pushed to lane2, drop_pulse=1 for one cycle, drop_cnt=1. Saturation check with CNT_WIDTH=2: 5 drops → drop_cnt=3.
5. Full lane0, continuous pe_ready[0]=1 with bus streaming id=0x01 → one beat per cycle after first pop, level constant, no data loss (scoreboard 64 beats).
6. Lanes holding data, assert config_state&&ce → levels 0, drop_cnt 0 next cycle. bus_valid during config_state → bus_ready=0, no drop counted. rst mid-stream → all outputs 0.

Source files
------------

// File: rtl/oct_router_pkg.sv
// Shared constants and helpers for the multi-lane multicast router.
package oct_router_pkg;

    function automatic logic [31:0] bcast_id(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    endfunction

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mc_router_mlane_if.sv
// Column-bus input and per-lane PE output handshake bundle for mc_router_mlane.
interface mc_router_mlane_if
    import oct_router_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = lvl_width(FIFO_DEPTH);

    logic [ID_WIDTH-1:0]          bus_id;
    logic [DATA_WIDTH-1:0]        bus_data;
    logic                         bus_valid;
    logic                         bus_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] pe_data;
    logic [NUM_CH-1:0]            pe_valid;
    logic [NUM_CH-1:0]            pe_ready;
    logic [NUM_CH*LVL_W-1:0]      fifo_level;

    modport master (
        output bus_id, bus_data, bus_valid, pe_ready,
        input  bus_ready, pe_data, pe_valid, fifo_level
    );

    modport slave (
        input  bus_id, bus_data, bus_valid, pe_ready,
        output bus_ready, pe_data, pe_valid, fifo_level
    );

endinterface

// File: rtl/mc_lane_fifo.sv
// Show-ahead lane FIFO with flush; head holds the last popped value while empty.
module mc_lane_fifo
    import oct_router_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = lvl_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic [LVL_W-1:0]      level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LVL_W-1:0]      count;
    logic [DATA_WIDTH-1:0] last_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = count;
    assign head    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Snapshot the head each cycle so it survives the pop that empties the lane.
            if (!empty) begin
                last_q <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mc_router_mlane.sv
// Multicast ID router: delivers each accepted bus beat to all matching lane FIFOs at once.
module mc_router_mlane
    import oct_router_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       config_state,
    input  logic                       ce,
    input  logic [NUM_CH*ID_WIDTH-1:0] cfg_id,
    input  logic [NUM_CH-1:0]          cfg_ch_en,
    mc_router_mlane_if.slave           bus,
    output logic                       drop_pulse,
    output logic [CNT_WIDTH-1:0]       drop_cnt,
    output logic                       cfg_locked
);
    localparam int LVL_W = lvl_width(FIFO_DEPTH);
    localparam logic [ID_WIDTH-1:0] BCAST = ID_WIDTH'(bcast_id(ID_WIDTH));

    logic [NUM_CH*ID_WIDTH-1:0]           id_q;
    logic [NUM_CH-1:0]                    en_q;
    logic                                 cfg_seen;
    logic [NUM_CH-1:0]                    match;
    logic [NUM_CH-1:0]                    full;
    logic [NUM_CH-1:0]                    empty;
    logic [NUM_CH-1:0]                    push;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    head;
    logic [NUM_CH-1:0][LVL_W-1:0]         level;
    logic                                 accept;
    logic                                 flush;
    logic                                 drop_now;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            match[i] = en_q[i] &&
                       ((bus.bus_id == id_q[lane_lsb(i, ID_WIDTH) +: ID_WIDTH]) ||
                        (bus.bus_id == BCAST));
        end
    end

    // All-or-none multicast: stall if any matching lane is full, never pushing a subset.
    assign bus.bus_ready = !config_state && !rst && (&(~match | ~full));
    assign accept        = bus.bus_valid && bus.bus_ready;
    assign push          = accept ? match : '0;
    assign drop_now      = accept && (match == '0);
    assign flush         = config_state && ce;

    assign bus.pe_data    = head;
    assign bus.pe_valid   = ~empty;
    assign bus.fifo_level = level;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        mc_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[g]),
            .pop   (bus.pe_ready[g]),
            .din   (bus.bus_data),
            .head  (head[g]),
            .empty (empty[g]),
            .full  (full[g]),
            .level (level[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= '0;
            en_q       <= '0;
            cfg_seen   <= 1'b0;
            cfg_locked <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            cfg_locked <= cfg_seen && !config_state;
            drop_pulse <= drop_now;
            if (flush) begin
                id_q     <= cfg_id;
                en_q     <= cfg_ch_en;
                cfg_seen <= 1'b1;
                drop_cnt <= '0;
            end else if (drop_now && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
